// File: rtl/fp_pkg.sv
// Shared floating-point format helpers for the pipelined multiplier.
package fp_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] exp;
    logic [MAN_W_DEF-1:0] man;
  } fp_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic exp_all_ones(input logic [31:0] e, input int exp_w);
    return e == ((32'd1 << exp_w) - 32'd1);
  endfunction

  function automatic logic is_zero(input logic [31:0] e);
    return e == '0;
  endfunction

endpackage

// File: rtl/fp_foil_mant.sv
// FOIL significand multiplier: partial products feed the S1 registers, and the
// registered partials are summed and normalised ahead of the S2 registers.
module fp_foil_mant #(
  parameter int MAN_W = 23,
  parameter int SPLIT = 12
) (
  input  logic [MAN_W:0]                   sig_a,
  input  logic [MAN_W:0]                   sig_b,
  output logic [2*(MAN_W+1-SPLIT)-1:0]     pp_hh,
  output logic [MAN_W:0]                   pp_hl,
  output logic [MAN_W:0]                   pp_lh,
  output logic [2*SPLIT-1:0]               pp_ll,
  input  logic [2*(MAN_W+1-SPLIT)-1:0]     r_hh,
  input  logic [MAN_W:0]                   r_hl,
  input  logic [MAN_W:0]                   r_lh,
  input  logic [2*SPLIT-1:0]               r_ll,
  input  logic                             approx,
  output logic                             norm,
  output logic [MAN_W-1:0]                 mant
);

  localparam int PW = 2*MAN_W + 2;

  logic [PW-1:0] prod;
  logic          unused_lsb;

  assign pp_hh = sig_a[MAN_W:SPLIT] * sig_b[MAN_W:SPLIT];
  assign pp_hl = sig_a[MAN_W:SPLIT] * sig_b[SPLIT-1:0];
  assign pp_lh = sig_a[SPLIT-1:0]   * sig_b[MAN_W:SPLIT];
  assign pp_ll = sig_a[SPLIT-1:0]   * sig_b[SPLIT-1:0];

  // Approximate mode simply leaves out the low x low term.
  assign prod = (PW'(r_hh) << (2*SPLIT))
              + ((PW'(r_hl) + PW'(r_lh)) << SPLIT)
              + (approx ? '0 : PW'(r_ll));

  assign norm       = prod[PW-1];
  assign mant       = norm ? prod[2*MAN_W:MAN_W+1] : prod[2*MAN_W-1:MAN_W];
  assign unused_lsb = ^prod[MAN_W-1:0];

endmodule

// File: rtl/fp_mult_pipe.sv
// 3-stage pipelined floating-point multiplier (unpack, sum/normalise, pack)
// with a single global stall driven by the output handshake.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int SPLIT = 12,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a_op,
  input  logic [EXP_W+MAN_W:0]     b_op,
  input  logic                     approx_en,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     exception,
  output logic                     overflow,
  output logic                     underflow,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int W    = EXP_W + MAN_W + 1;
  localparam int HI_W = MAN_W + 1 - SPLIT;
  localparam int EW   = EXP_W + 2;
  localparam logic [EW-1:0] BIAS_W = EW'(fp_bias(EXP_W));
  localparam logic [EW-1:0] EMAX_W = EW'((1 << EXP_W) - 1);

  logic               advance;
  logic [EXP_W-1:0]   a_exp, b_exp;
  logic [2*HI_W-1:0]  pp_hh;
  logic [MAN_W:0]     pp_hl, pp_lh;
  logic [2*SPLIT-1:0] pp_ll;
  logic               norm;
  logic [MAN_W-1:0]   mant;

  logic               s1_valid, s1_sign, s1_zero, s1_exc, s1_approx;
  logic [TAG_W-1:0]   s1_tag;
  logic [EXP_W-1:0]   s1_ea, s1_eb;
  logic [2*HI_W-1:0]  s1_hh;
  logic [MAN_W:0]     s1_hl, s1_lh;
  logic [2*SPLIT-1:0] s1_ll;

  logic               s2_valid, s2_sign, s2_zero, s2_exc;
  logic [TAG_W-1:0]   s2_tag;
  logic [EW-1:0]      s2_exp;
  logic [MAN_W-1:0]   s2_mant;

  logic               ovf_c, unf_c;
  logic [W-1:0]       res_c;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign a_exp    = a_op[W-2:MAN_W];
  assign b_exp    = b_op[W-2:MAN_W];

  fp_foil_mant #(.MAN_W(MAN_W), .SPLIT(SPLIT)) u_foil (
    .sig_a  ({1'b1, a_op[MAN_W-1:0]}),
    .sig_b  ({1'b1, b_op[MAN_W-1:0]}),
    .pp_hh  (pp_hh),
    .pp_hl  (pp_hl),
    .pp_lh  (pp_lh),
    .pp_ll  (pp_ll),
    .r_hh   (s1_hh),
    .r_hl   (s1_hl),
    .r_lh   (s1_lh),
    .r_ll   (s1_ll),
    .approx (s1_approx),
    .norm   (norm),
    .mant   (mant)
  );

  // Data registers only load with a valid token so idle cycles keep them quiet.
  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      s1_sign   <= a_op[W-1] ^ b_op[W-1];
      s1_zero   <= is_zero(32'(a_exp)) || is_zero(32'(b_exp));
      s1_exc    <= exp_all_ones(32'(a_exp), EXP_W) || exp_all_ones(32'(b_exp), EXP_W);
      s1_approx <= approx_en;
      s1_tag    <= in_tag;
      s1_ea     <= a_exp;
      s1_eb     <= b_exp;
      s1_hh     <= pp_hh;
      s1_hl     <= pp_hl;
      s1_lh     <= pp_lh;
      s1_ll     <= pp_ll;
    end
    if (advance && s1_valid) begin
      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_exc  <= s1_exc;
      s2_tag  <= s1_tag;
      s2_exp  <= EW'(s1_ea) + EW'(s1_eb) - BIAS_W + EW'(norm);
      s2_mant <= mant;
    end
  end

  assign ovf_c = !s2_zero && !s2_exc && ($signed(s2_exp) >= $signed(EMAX_W));
  assign unf_c = !s2_zero && !s2_exc && (s2_exp[EW-1] || (s2_exp == '0));

  always_comb begin
    res_c = {s2_sign, s2_exp[EXP_W-1:0], s2_mant};
    if (s2_exc || ovf_c)
      res_c = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (s2_zero || unf_c)
      res_c = {s2_sign, {(W-1){1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      exception <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      out_tag   <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        result    <= res_c;
        exception <= s2_exc;
        overflow  <= ovf_c;
        underflow <= unf_c;
        out_tag   <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe: directed vectors, randomized traffic with stalls,
// backpressure ordering and reset while operations are in flight.
module tb_fp_mult_pipe;
  import fp_pkg::*;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int SPLIT = 12;
  localparam int TAG_W = 4;
  localparam int W     = EXP_W + MAN_W + 1;
  localparam int OW    = W + 3 + TAG_W;
  localparam longint BIAS = 127;
  localparam longint EMAX = 255;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a_op = '0;
  logic [W-1:0]     b_op = '0;
  logic             approx_en = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     result;
  logic             exception, overflow, underflow;
  logic [TAG_W-1:0] out_tag;

  int total = 0;
  int bad   = 0;
  logic [OW-1:0] exp_q[$];

  always #5 clk = ~clk;

  fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .SPLIT(SPLIT), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_op      (a_op),
    .b_op      (b_op),
    .approx_en (approx_en),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .exception (exception),
    .overflow  (overflow),
    .underflow (underflow),
    .out_tag   (out_tag)
  );

  // Reference: full integer product of the significands, minus low*low when approximate.
  function automatic logic [OW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ap, input logic [TAG_W-1:0] t);
    fp_t    fa, fb;
    longint ea, eb, sa, sb, prod, mant, e;
    logic   zero, exc, ovf, unf, norm, sgn;
    logic [W-1:0] r;
    fa = a;
    fb = b;
    ea = longint'(fa.exp);
    eb = longint'(fb.exp);
    sgn  = fa.sign ^ fb.sign;
    zero = (ea == 0) || (eb == 0);
    exc  = (ea == EMAX) || (eb == EMAX);
    sa = (longint'(1) << MAN_W) + longint'(fa.man);
    sb = (longint'(1) << MAN_W) + longint'(fb.man);
    prod = sa * sb;
    if (ap) prod = prod - (sa % (longint'(1) << SPLIT)) * (sb % (longint'(1) << SPLIT));
    norm = prod >= (longint'(1) << (2*MAN_W + 1));
    mant = (norm ? (prod >> (MAN_W + 1)) : (prod >> MAN_W)) % (longint'(1) << MAN_W);
    e = ea + eb - BIAS + (norm ? 1 : 0);
    ovf = !zero && !exc && (e >= EMAX);
    unf = !zero && !exc && (e <= 0);
    if (exc || ovf)       r = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (zero || unf) r = {sgn, {(W-1){1'b0}}};
    else                  r = {sgn, e[EXP_W-1:0], mant[MAN_W-1:0]};
    return {r, exc, ovf, unf, t};
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [EXP_W-1:0] e;
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0:       e = '0;
      1:       e = '1;
      2:       e = 8'h01;
      3:       e = 8'($urandom_range(0, 255));
      default: e = 8'($urandom_range(97, 157));
    endcase
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // Called just after a falling edge with inputs set; returns what the next rising edge transfers.
  task automatic tick(output logic inf, output logic of, output logic rdy,
                      output logic vld, output logic [OW-1:0] obs);
    #1;
    rdy = in_ready;
    vld = out_valid;
    inf = in_valid & in_ready & rst_n;
    of  = out_valid & out_ready;
    obs = {result, exception, overflow, underflow, out_tag};
    if (inf) exp_q.push_back(model(a_op, b_op, approx_en, in_tag));
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++;
    if ({result, exception, overflow, underflow, out_tag} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", {result, exception, overflow, underflow, out_tag});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] va[7], vb[7], vr[7];
    logic [2:0]  vf[7];
    logic        vap[7];
    logic        inf, of, rdy, vld, got;
    logic [OW-1:0] obs, e;
    int lat;
    va  = '{32'h40000000, 32'h3F800FFF, 32'h3F800FFF, 32'h7F000000, 32'h7F800000, 32'h00800000, 32'h80000000};
    vb  = '{32'h40400000, 32'h3F800FFF, 32'h3F800FFF, 32'h7F000000, 32'h00000000, 32'h00800000, 32'h3F800000};
    vap = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vr  = '{32'h40C00000, 32'h3F801FFF, 32'h3F801FFE, 32'h7F800000, 32'h7F800000, 32'h00000000, 32'h80000000};
    vf  = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b100, 3'b001, 3'b000};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a_op = va[i];
      b_op = vb[i];
      approx_en = vap[i];
      in_tag = TAG_W'(i + 3);
      in_valid = 1'b1;
      tick(inf, of, rdy, vld, obs);
      in_valid = 1'b0;
      total++;
      if (inf !== 1'b1) begin bad++; $display("FAIL directed_%0d accept: got %b want 1", i, inf); end
      lat = 0;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        tick(inf, of, rdy, vld, obs);
        lat++;
        if (of) got = 1'b1;
      end
      total++;
      if (!got) begin
        bad++;
        $display("FAIL directed_%0d timeout: got no result want one", i);
      end else begin
        total++;
        if (lat != 3) begin bad++; $display("FAIL directed_%0d latency: got %0d want 3", i, lat); end
        total++;
        if (obs[OW-1 -: W] !== vr[i]) begin
          bad++; $display("FAIL directed_%0d result: got %h want %h", i, obs[OW-1 -: W], vr[i]);
        end
        total++;
        if (obs[TAG_W+2 -: 3] !== vf[i]) begin
          bad++; $display("FAIL directed_%0d flags: got %b want %b", i, obs[TAG_W+2 -: 3], vf[i]);
        end
        total++;
        if (obs[TAG_W-1:0] !== TAG_W'(i + 3)) begin
          bad++; $display("FAIL directed_%0d tag: got %0d want %0d", i, obs[TAG_W-1:0], i + 3);
        end
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL directed_%0d model: got %h want %h", i, obs, e); end
      end
    end
  endtask

  task automatic test_random();
    logic inf, of, rdy, vld, stalled_prev;
    logic [OW-1:0] obs, prev_obs, e;
    logic [TAG_W-1:0] tag_n;
    stalled_prev = 1'b0;
    prev_obs = '0;
    tag_n = '0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a_op      = rand_op();
      b_op      = rand_op();
      approx_en = 1'($urandom_range(0, 1));
      in_tag    = tag_n;
      out_ready = ($urandom_range(0, 3) != 0);
      tick(inf, of, rdy, vld, obs);
      total++;
      if (rdy !== (!vld || out_ready)) begin
        bad++; $display("FAIL rand_in_ready: got %b want %b", rdy, !vld || out_ready);
      end
      if (stalled_prev) begin
        total++;
        if (!vld || obs !== prev_obs) begin
          bad++; $display("FAIL rand_hold: got %b/%h want 1/%h", vld, obs, prev_obs);
        end
      end
      if (of) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_extra: got %h want no result", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin bad++; $display("FAIL rand_result: got %h want %h", obs, e); end
        end
      end
      if (inf) tag_n++;
      stalled_prev = vld & !out_ready;
      prev_obs = obs;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      tick(inf, of, rdy, vld, obs);
      if (of) begin
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL rand_drain: got %h want %h", obs, e); end
      end
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rand_lost: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic inf, of, rdy, vld, stalled_prev;
    logic [OW-1:0] obs, prev_obs, e;
    int idx, held, nfired, nstall;
    idx = 0; held = 0; nfired = 0; nstall = 0;
    stalled_prev = 1'b0;
    prev_obs = '0;
    exp_q.delete();
    a_op = rand_op(); b_op = rand_op(); approx_en = 1'($urandom_range(0, 1));
    in_tag = '0;
    in_valid = 1'b1;
    for (int c = 0; c < 60 && nfired < 6; c++) begin
      if (out_valid) held++;
      out_ready = (held > 5);
      tick(inf, of, rdy, vld, obs);
      if (vld && !out_ready) begin
        nstall++;
        total++;
        if (rdy !== 1'b0) begin bad++; $display("FAIL b2b_in_ready: got %b want 0", rdy); end
      end
      if (stalled_prev) begin
        total++;
        if (!vld || obs !== prev_obs) begin
          bad++; $display("FAIL b2b_hold: got %b/%h want 1/%h", vld, obs, prev_obs);
        end
      end
      if (of) begin
        total++;
        if (obs[TAG_W-1:0] !== TAG_W'(nfired)) begin
          bad++; $display("FAIL b2b_order: got tag %0d want %0d", obs[TAG_W-1:0], nfired);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra: got %h want no result", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin bad++; $display("FAIL b2b_result: got %h want %h", obs, e); end
        end
        nfired++;
      end
      if (inf) begin
        idx++;
        if (idx < 6) begin
          a_op = rand_op(); b_op = rand_op(); approx_en = 1'($urandom_range(0, 1));
          in_tag = TAG_W'(idx);
        end else begin
          in_valid = 1'b0;
        end
      end
      stalled_prev = vld & !out_ready;
      prev_obs = obs;
    end
    total++;
    if (nfired != 6) begin bad++; $display("FAIL b2b_count: got %0d want 6", nfired); end
    total++;
    if (nstall != 5) begin bad++; $display("FAIL b2b_stall_cycles: got %0d want 5", nstall); end
    in_valid = 1'b0;
    repeat (4) tick(inf, of, rdy, vld, obs);
    total++;
    if (exp_q.size() != 0 || vld) begin
      bad++; $display("FAIL b2b_dup: got %0d pending valid=%b want 0/0", exp_q.size(), vld);
    end
  endtask

  task automatic test_reset_midflight();
    logic inf, of, rdy, vld, got;
    logic [OW-1:0] obs, e;
    int lat;
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a_op = rand_op(); b_op = rand_op(); in_tag = TAG_W'(i + 9);
      tick(inf, of, rdy, vld, obs);
      total++;
      if (inf !== 1'b1) begin bad++; $display("FAIL mid_accept_%0d: got %b want 1", i, inf); end
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || result !== '0) begin
      bad++; $display("FAIL mid_reset_outputs: got valid=%b result=%h want 0/0", out_valid, result);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(inf, of, rdy, vld, obs);
      total++;
      if (vld !== 1'b0) begin bad++; $display("FAIL mid_stale_%0d: got valid=%b want 0", i, vld); end
    end
    a_op = 32'h40000000; b_op = 32'h40400000; approx_en = 1'b0; in_tag = 4'd5;
    in_valid = 1'b1;
    tick(inf, of, rdy, vld, obs);
    in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick(inf, of, rdy, vld, obs);
      lat++;
      if (of) got = 1'b1;
    end
    total++;
    if (!got || lat != 3) begin
      bad++; $display("FAIL mid_latency: got %0d (seen=%b) want 3", lat, got);
    end
    total++;
    if (exp_q.size() != 1) begin
      bad++; $display("FAIL mid_queue: got %0d pending want 1", exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin bad++; $display("FAIL mid_result: got %h want %h", obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
